// File: rtl/avmm2axi_lite_pkg.sv
// rtl/avmm2axi_lite_pkg.sv - shared types and constants for the Avalon-MM to AXI4-Lite bridge
package avmm2axi_lite_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } avmm2axi_state_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/avmm2axi_lite.sv
// rtl/avmm2axi_lite.sv - single-outstanding Avalon-MM slave to AXI4-Lite master bridge
module avmm2axi_lite
  import avmm2axi_lite_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 64,
  localparam int BW = DW / 8
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [BW-1:0] avs_byteenable,
  input  logic [DW-1:0] avs_writedata,
  input  logic          avs_burstcount,
  output logic          avs_waitrequest,
  output logic [DW-1:0] avs_readdata,
  output logic          avs_readdatavalid,
  output logic [1:0]    avs_response,
  output logic          avs_writeresponsevalid,
  output logic [AW-1:0] m_axi_awaddr,
  output logic [2:0]    m_axi_awprot,
  output logic          m_axi_awvalid,
  input  logic          m_axi_awready,
  output logic [DW-1:0] m_axi_wdata,
  output logic [BW-1:0] m_axi_wstrb,
  output logic          m_axi_wvalid,
  input  logic          m_axi_wready,
  input  logic [1:0]    m_axi_bresp,
  input  logic          m_axi_bvalid,
  output logic          m_axi_bready,
  output logic [AW-1:0] m_axi_araddr,
  output logic [2:0]    m_axi_arprot,
  output logic          m_axi_arvalid,
  input  logic          m_axi_arready,
  input  logic [DW-1:0] m_axi_rdata,
  input  logic [1:0]    m_axi_rresp,
  input  logic          m_axi_rvalid,
  output logic          m_axi_rready,
  output logic [15:0]   err_cnt
);

  avmm2axi_state_t r_state, w_state_next;

  logic          r_waitreq;
  logic [DW-1:0] r_readdata;
  logic          r_readdatavalid;
  logic [1:0]    r_response;
  logic          r_wrrespvalid;
  logic [AW-1:0] r_awaddr;
  logic          r_awvalid;
  logic [DW-1:0] r_wdata;
  logic [BW-1:0] r_wstrb;
  logic          r_wvalid;
  logic          r_bready;
  logic [AW-1:0] r_araddr;
  logic          r_arvalid;
  logic          r_rready;
  logic          r_aw_done;
  logic          r_w_done;
  logic [15:0]   r_err_cnt;

  logic w_acc, w_conflict, w_aw_hs, w_w_hs, w_wr_req_done;
  logic w_ar_hs, w_b_hs, w_r_hs, w_err;
  logic w_unused_burstcount;

  assign w_unused_burstcount = avs_burstcount;

  assign w_acc         = (r_state == ST_IDLE) && !r_waitreq && (avs_read || avs_write);
  assign w_conflict    = w_acc && avs_read && avs_write;
  assign w_aw_hs       = r_awvalid && m_axi_awready;
  assign w_w_hs        = r_wvalid && m_axi_wready;
  assign w_wr_req_done = (r_state == ST_WR_REQ) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_ar_hs       = r_arvalid && m_axi_arready;
  assign w_b_hs        = (r_state == ST_WR_RESP) && m_axi_bvalid && r_bready;
  assign w_r_hs        = (r_state == ST_RD_RESP) && m_axi_rvalid && r_rready;
  // A dropped read on a read/write collision is counted like a bus error
  assign w_err         = w_conflict
                      || (w_b_hs && (axi_resp_t'(m_axi_bresp) != AXI_OKAY))
                      || (w_r_hs && (axi_resp_t'(m_axi_rresp) != AXI_OKAY));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_acc) w_state_next = avs_write ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (w_wr_req_done) w_state_next = ST_WR_RESP;
      ST_WR_RESP: if (w_b_hs) w_state_next = ST_IDLE;
      ST_RD_REQ:  if (w_ar_hs) w_state_next = ST_RD_RESP;
      ST_RD_RESP: if (w_r_hs) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_waitreq       <= 1'b1;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
      r_response      <= 2'b00;
      r_wrrespvalid   <= 1'b0;
      r_awaddr        <= '0;
      r_awvalid       <= 1'b0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_wvalid        <= 1'b0;
      r_bready        <= 1'b0;
      r_araddr        <= '0;
      r_arvalid       <= 1'b0;
      r_rready        <= 1'b0;
      r_aw_done       <= 1'b0;
      r_w_done        <= 1'b0;
      r_err_cnt       <= 16'd0;
    end else begin
      r_waitreq       <= (w_state_next != ST_IDLE);
      r_readdatavalid <= 1'b0;
      r_wrrespvalid   <= 1'b0;
      if (w_err) r_err_cnt <= sat_inc16(r_err_cnt);

      if (w_acc && avs_write) begin
        r_awaddr  <= avs_address;
        r_wdata   <= avs_writedata;
        r_wstrb   <= avs_byteenable;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (w_acc) begin
        r_araddr  <= avs_address;
        r_arvalid <= 1'b1;
      end

      // AW and W complete independently; either may finish first
      if (r_state == ST_WR_REQ) begin
        if (w_aw_hs) begin
          r_awvalid <= 1'b0;
          r_aw_done <= 1'b1;
        end
        if (w_w_hs) begin
          r_wvalid <= 1'b0;
          r_w_done <= 1'b1;
        end
        if (w_wr_req_done) r_bready <= 1'b1;
      end

      if (w_b_hs) begin
        r_bready      <= 1'b0;
        r_wrrespvalid <= 1'b1;
        r_response    <= m_axi_bresp;
      end

      if ((r_state == ST_RD_REQ) && w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end

      if (w_r_hs) begin
        r_rready        <= 1'b0;
        r_readdatavalid <= 1'b1;
        r_readdata      <= m_axi_rdata;
        r_response      <= m_axi_rresp;
      end
    end
  end

  assign avs_waitrequest        = r_waitreq;
  assign avs_readdata           = r_readdata;
  assign avs_readdatavalid      = r_readdatavalid;
  assign avs_response           = r_response;
  assign avs_writeresponsevalid = r_wrrespvalid;
  assign m_axi_awaddr           = r_awaddr;
  assign m_axi_awprot           = AXI_PROT_DEFAULT;
  assign m_axi_awvalid          = r_awvalid;
  assign m_axi_wdata            = r_wdata;
  assign m_axi_wstrb            = r_wstrb;
  assign m_axi_wvalid           = r_wvalid;
  assign m_axi_bready           = r_bready;
  assign m_axi_araddr           = r_araddr;
  assign m_axi_arprot           = AXI_PROT_DEFAULT;
  assign m_axi_arvalid          = r_arvalid;
  assign m_axi_rready           = r_rready;
  assign err_cnt                = r_err_cnt;

endmodule
